// File: rtl/xcorr_pe_pipe.sv
// xcorr_pe_pipe: XOR/popcount cross-correlation PE with per-frame accumulation,
// threshold verdict, and latency-matched template/mark forwarding for systolic chaining.
module xcorr_pe_pipe #(
  parameter int W        = 100,
  parameter int ACC_W    = 9,
  parameter int PIPE_POP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [W-1:0]     iarray,
  input  logic [W-1:0]     tarray,
  input  logic             mark,
  input  logic             valid,
  input  logic             flush,
  input  logic [ACC_W-1:0] thr,
  output logic [W-1:0]     tout,
  output logic             markout,
  output logic [ACC_W-1:0] score,
  output logic             score_vld,
  output logic             hit,
  output logic             sat
);
  localparam int CW = $clog2(W + 1);
  localparam logic [ACC_W:0]   MAX_W = {1'b0, {ACC_W{1'b1}}};
  localparam logic [ACC_W-1:0] MAX_A = '1;
  logic [CW-1:0] pc, pa;
  logic ma, va, fa;
  logic [W-1:0] ta;
  always_comb begin
    pc = '0;
    for (int i = 0; i < W; i++) pc = pc + CW'(iarray[i] ^ tarray[i]);
  end
  generate
    if (PIPE_POP != 0) begin : g_pipe
      logic [CW-1:0] pc_q;
      logic mark_q, valid_q, flush_q;
      logic [W-1:0] t_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pc_q    <= '0;
          mark_q  <= 1'b0;
          valid_q <= 1'b0;
          flush_q <= 1'b0;
          t_q     <= '0;
        end else if (!stall) begin
          pc_q    <= pc;
          mark_q  <= mark;
          valid_q <= valid;
          flush_q <= flush;
          t_q     <= tarray;
        end
      end
      assign pa = pc_q;
      assign ma = mark_q;
      assign va = valid_q;
      assign fa = flush_q;
      assign ta = t_q;
    end else begin : g_comb
      assign pa = pc;
      assign ma = mark;
      assign va = valid;
      assign fa = flush;
      assign ta = tarray;
    end
  endgenerate
  logic [ACC_W-1:0] acc_q, acc_d, thr_q, thr_d, score_q, score_d;
  logic open_q, open_d, bad_q, bad_d, satf_q, satf_d;
  logic vld_q, vld_d, hit_q, hit_d, sat_q, sat_d, mo_q;
  logic [W-1:0] tout_q;
  logic [ACC_W:0] sum;
  logic close, grow;
  // Verdict always reflects the accumulator before the closing word; mark beats flush.
  always_comb begin
    sum     = {1'b0, acc_q} + (ACC_W+1)'(pa);
    close   = open_q & (ma | fa);
    grow    = open_q & !ma & !fa;
    acc_d   = ma ? ACC_W'(pa) : !open_q ? acc_q : fa ? '0 : (sum > MAX_W ? MAX_A : sum[ACC_W-1:0]);
    bad_d   = ma ? !va : grow ? (bad_q | !va) : bad_q;
    satf_d  = ma ? 1'b0 : grow ? (satf_q | (sum > MAX_W)) : satf_q;
    thr_d   = ma ? thr : thr_q;
    open_d  = ma | (open_q & !fa);
    vld_d   = close;
    score_d = close ? acc_q : score_q;
    sat_d   = close ? satf_q : sat_q;
    hit_d   = close ? (!bad_q & !satf_q & (acc_q <= thr_q)) : hit_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      thr_q   <= '0;
      score_q <= '0;
      open_q  <= 1'b0;
      bad_q   <= 1'b0;
      satf_q  <= 1'b0;
      vld_q   <= 1'b0;
      hit_q   <= 1'b0;
      sat_q   <= 1'b0;
      mo_q    <= 1'b0;
      tout_q  <= '0;
    end else if (!stall) begin
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      score_q <= score_d;
      open_q  <= open_d;
      bad_q   <= bad_d;
      satf_q  <= satf_d;
      vld_q   <= vld_d;
      hit_q   <= hit_d;
      sat_q   <= sat_d;
      mo_q    <= ma;
      tout_q  <= ta;
    end
  end
  assign tout      = tout_q;
  assign markout   = mo_q;
  assign score     = score_q;
  assign score_vld = vld_q;
  assign hit       = hit_q;
  assign sat       = sat_q;
endmodule

// File: tb/tb_xcorr_pe_pipe.sv
// tb_xcorr_pe_pipe: drives PIPE_POP=0 and PIPE_POP=1 instances with one stimulus and
// checks both against a frame-level reference computed from the applied word history.
module tb_xcorr_pe_pipe;
  localparam int W = 100;
  localparam int AW = 9;
  localparam int AMAX = (1 << AW) - 1;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, mark = 1'b0, valid = 1'b0, flush = 1'b0;
  logic [W-1:0] iarray = '0, tarray = '0;
  logic [AW-1:0] thr = '0;
  logic [W-1:0] tout0, tout1;
  logic [AW-1:0] score0, score1;
  logic markout0, markout1, vld0, vld1, hit0, hit1, sat0, sat1;
  xcorr_pe_pipe #(.W(W), .ACC_W(AW), .PIPE_POP(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .iarray(iarray), .tarray(tarray), .mark(mark),
    .valid(valid), .flush(flush), .thr(thr), .tout(tout0), .markout(markout0),
    .score(score0), .score_vld(vld0), .hit(hit0), .sat(sat0));
  xcorr_pe_pipe #(.W(W), .ACC_W(AW), .PIPE_POP(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .iarray(iarray), .tarray(tarray), .mark(mark),
    .valid(valid), .flush(flush), .thr(thr), .tout(tout1), .markout(markout1),
    .score(score1), .score_vld(vld1), .hit(hit1), .sat(sat1));
  always #5 clk = ~clk;
  int n_vec = 0, n_mis = 0, s = 0;
  bit h_mark[4096], h_valid[4096], h_flush[4096];
  int h_pc[4096], h_thr[4096];
  logic [W-1:0] h_t[4096];
  int e_score[2];
  bit e_hit[2], e_sat[2], e_vld[2];
  // Word j closes a frame if the nearest earlier mark is not separated from it by a flush.
  function automatic void frame_at(input int j, input int p, output bit cl, output int sc,
                                   output bit ht, output bit st);
    int m = -1;
    bit bad = 1'b0;
    cl = 1'b0; sc = 0; ht = 1'b0; st = 1'b0;
    if (!(h_mark[j] || h_flush[j])) return;
    for (int k = j - 1; k >= 0; k--) begin
      if (h_mark[k]) begin m = k; break; end
      if (h_flush[k]) break;
    end
    if (m < 0) return;
    cl = 1'b1;
    for (int k = m; k < j; k++) begin
      sc += h_pc[k];
      if (sc > AMAX) begin sc = AMAX; st = 1'b1; end
      bad |= !h_valid[k];
    end
    ht = !bad && !st && (sc <= h_thr[m + p]);
  endfunction
  task automatic chk(input string tag, input int p, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s pipe%0d obs=%0h exp=%0h", tag, p, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      int j = s - 1 - p;
      chk("tout", p, p ? tout1 : tout0, j >= 0 ? h_t[j] : '0);
      chk("markout", p, W'(p ? markout1 : markout0), W'(j >= 0 ? h_mark[j] : 1'b0));
      chk("score_vld", p, W'(p ? vld1 : vld0), W'(e_vld[p]));
      chk("score", p, W'(p ? score1 : score0), W'(e_score[p]));
      chk("hit", p, W'(p ? hit1 : hit0), W'(e_hit[p]));
      chk("sat", p, W'(p ? sat1 : sat0), W'(e_sat[p]));
    end
  endtask
  task automatic step(input bit mk, input bit v, input bit fl, input int k, input int th, input bit st);
    logic [127:0] r;
    logic [W-1:0] msk = '0;
    bit cl, ht, sa;
    int sc;
    r = {$urandom, $urandom, $urandom, $urandom};
    while ($countones(msk) < k) msk[$urandom_range(W - 1, 0)] = 1'b1;
    tarray = r[W-1:0]; iarray = r[W-1:0] ^ msk;
    mark = mk; valid = v; flush = fl; thr = AW'(th); stall = st;
    @(posedge clk); #1;
    if (!st) begin
      h_mark[s] = mk; h_valid[s] = v; h_flush[s] = fl; h_pc[s] = k; h_thr[s] = th; h_t[s] = tarray;
      for (int p = 0; p < 2; p++) begin
        e_vld[p] = 1'b0;
        if (s - p >= 0) begin
          frame_at(s - p, p, cl, sc, ht, sa);
          if (cl) begin e_vld[p] = 1'b1; e_score[p] = sc; e_hit[p] = ht; e_sat[p] = sa; end
        end
      end
      s++;
    end
    check_all();
  endtask
  task automatic do_reset();
    rst = 1'b0; stall = 1'b0;
    #1;
    s = 0;
    for (int p = 0; p < 2; p++) begin e_score[p] = 0; e_hit[p] = 0; e_sat[p] = 0; e_vld[p] = 0; end
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b1;
  endtask
  initial begin
    do_reset();
    step(1, 1, 0, 10, 100, 0);
    chk("s1_novld0", 0, W'(vld0), W'(1'b0));
    step(0, 1, 0, 20, 100, 0);
    step(0, 1, 0, 30, 100, 0);
    step(1, 1, 0, 10, 59, 0);
    chk("s1_vld", 0, W'(vld0), W'(1'b1));
    chk("s1_score", 0, W'(score0), W'(60));
    chk("s1_hit", 0, W'(hit0), W'(1'b1));
    step(0, 1, 0, 20, 59, 0);
    chk("s1_score", 1, W'(score1), W'(60));
    chk("s1_hit", 1, W'(hit1), W'(1'b1));
    chk("s1_vld_once", 0, W'(vld0), W'(1'b0));
    step(0, 1, 0, 30, 200, 0);
    step(1, 1, 0, 100, 511, 0);
    chk("s2_hit", 0, W'(hit0), W'(1'b0));
    chk("s2_score", 0, W'(score0), W'(60));
    repeat (5) step(0, 1, 0, 100, 511, 0);
    step(0, 1, 1, 100, 511, 0);
    chk("s3_score", 0, W'(score0), W'(511));
    chk("s3_sat", 0, W'(sat0), W'(1'b1));
    step(1, 1, 0, 5, 100, 0);
    chk("s3_score", 1, W'(score1), W'(511));
    chk("s3_sat", 1, W'(sat1), W'(1'b1));
    chk("s3_noverdict", 0, W'(vld0), W'(1'b0));
    step(0, 0, 0, 5, 100, 0);
    step(0, 1, 0, 5, 100, 0);
    step(1, 1, 0, 5, 100, 0);
    step(0, 1, 0, 5, 100, 0);
    step(0, 1, 0, 5, 100, 0);
    step(1, 1, 0, 10, 100, 0);
    step(0, 1, 0, 10, 100, 0);
    repeat (3) step(0, 1, 0, 10, 100, 1);
    step(0, 1, 0, 10, 100, 0);
    step(1, 1, 0, 20, 100, 0);
    repeat (2) step(1, 1, 0, 20, 100, 1);
    step(0, 1, 0, 20, 100, 0);
    step(0, 1, 0, 20, 100, 0);
    do_reset();
    step(1, 1, 0, 0, 100, 0);
    step(0, 1, 0, 7, 100, 0);
    step(1, 1, 0, 3, 100, 0);
    chk("s6_score", 0, W'(score0), W'(7));
    chk("s6_hit", 0, W'(hit0), W'(1'b1));
    step(0, 1, 0, 3, 100, 0);
    chk("s6_score", 1, W'(score1), W'(7));
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step($urandom_range(4) == 0, $urandom_range(15) != 0, $urandom_range(9) == 0,
           $urandom_range(1) ? int'($urandom_range(10)) : int'($urandom_range(100)),
           int'($urandom_range(AMAX)), $urandom_range(7) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
